// File: rtl/rs_multi_issue.sv
// Multi-issue reservation station: age-ordered collapsing queue that issues up to
// NUM_PE packets per cycle, preferring entries tagged for the current replay iteration.
module rs_multi_issue #(
  parameter int ENTRIES     = 8,
  parameter int NUM_PE      = 4,
  parameter int PKT_W       = 14,
  parameter int ITER_LSB    = 7,
  parameter int ITER_W      = 3,
  parameter int BANK_STRICT = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush,
  input  logic                                       in_valid,
  input  logic [PKT_W-1:0]                           in_packet,
  output logic                                       in_ready,
  input  logic [(ITER_W > 1 ? $clog2(ITER_W) : 1)-1:0] replay_iter,
  input  logic [NUM_PE-1:0]                          pe_idle,
  input  logic [NUM_PE-1:0]                          bank_busy,
  output logic [NUM_PE-1:0]                          dp_valid,
  output logic [NUM_PE*PKT_W-1:0]                    dp_packet,
  output logic [$clog2(ENTRIES+1)-1:0]               count,
  output logic                                       rs_empty,
  output logic                                       rs_full
);

  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int MAXR  = (ENTRIES > NUM_PE) ? ENTRIES : NUM_PE;
  localparam int RK_W  = $clog2(MAXR + 1);

  logic [PKT_W-1:0] r_slot [ENTRIES];
  logic [CNT_W-1:0] r_count;

  logic [PKT_W-1:0]  w_slot_next [ENTRIES];
  logic [CNT_W-1:0]  w_count_next;
  logic [CNT_W-1:0]  w_issued;
  logic [CNT_W-1:0]  w_wr_idx;
  logic [ENTRIES-1:0] w_valid;
  logic [ENTRIES-1:0] w_match;
  logic [ENTRIES-1:0] w_cand;
  logic [ENTRIES-1:0] w_issue;
  logic [NUM_PE-1:0] w_elig;
  logic [RK_W-1:0]   w_c_rank [ENTRIES];
  logic [RK_W-1:0]   w_e_rank [NUM_PE];
  logic [CNT_W-1:0]  w_s_rank [ENTRIES];
  logic [RK_W-1:0]   w_cn;
  logic [RK_W-1:0]   w_en;
  logic [CNT_W-1:0]  w_sn;
  logic              w_accept;

  assign w_elig   = (BANK_STRICT != 0) ? (pe_idle & {NUM_PE{~|bank_busy}})
                                       : (pe_idle & ~bank_busy);
  // Reset cycle reports ready (matching the post-reset state) but never writes.
  assign in_ready = reset | (~flush & (r_count < CNT_W'(ENTRIES)));
  assign w_accept = in_valid & in_ready & ~reset & ~flush;
  assign count    = r_count;
  assign rs_empty = (r_count == '0);
  assign rs_full  = (r_count == CNT_W'(ENTRIES));

  always_comb begin
    w_cn         = '0;
    w_en         = '0;
    w_sn         = '0;
    w_issued     = '0;
    w_issue      = '0;
    dp_valid     = '0;
    dp_packet    = '0;

    // Shifting a one past the mask width yields no match for out-of-range iterations.
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_valid[i] = (CNT_W'(i) < r_count);
      w_match[i] = w_valid[i] &
                   (|(r_slot[i][ITER_LSB +: ITER_W] & (ITER_W'(1) << replay_iter)));
    end
    w_cand = (|w_match) ? w_match : w_valid;

    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_c_rank[i] = w_cn;
      if (w_cand[i]) w_cn = w_cn + RK_W'(1);
    end
    for (int unsigned j = 0; j < NUM_PE; j++) begin
      w_e_rank[j] = w_en;
      if (w_elig[j]) w_en = w_en + RK_W'(1);
    end

    // n-th candidate pairs with n-th eligible PE; unmatched ranks simply drop out.
    if (!reset && !flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        for (int unsigned j = 0; j < NUM_PE; j++) begin
          if (w_cand[i] && w_elig[j] && (w_c_rank[i] == w_e_rank[j])) begin
            dp_valid[j]                  = 1'b1;
            dp_packet[j*PKT_W +: PKT_W]  = r_slot[i];
            w_issue[i]                   = 1'b1;
          end
        end
      end
    end

    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_s_rank[i] = w_sn;
      if (w_valid[i] && !w_issue[i]) w_sn = w_sn + CNT_W'(1);
      if (w_issue[i]) w_issued = w_issued + CNT_W'(1);
    end

    w_wr_idx = r_count - w_issued;
    for (int unsigned d = 0; d < ENTRIES; d++) begin
      w_slot_next[d] = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (w_valid[i] && !w_issue[i] && (w_s_rank[i] == CNT_W'(d)))
          w_slot_next[d] = r_slot[i];
      end
      if (w_accept && (CNT_W'(d) == w_wr_idx))
        w_slot_next[d] = in_packet;
    end
    w_count_next = w_wr_idx + CNT_W'(w_accept);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
      for (int unsigned d = 0; d < ENTRIES; d++) r_slot[d] <= '0;
    end else begin
      r_count <= w_count_next;
      for (int unsigned d = 0; d < ENTRIES; d++) r_slot[d] <= w_slot_next[d];
    end
  end

endmodule

// File: tb/tb_rs_multi_issue.sv
// Bench for rs_multi_issue: strict and per-bank instances share stimulus and are
// each checked every cycle against a queue-based reference model.
module tb_rs_multi_issue;
  localparam int E   = 8;
  localparam int P   = 4;
  localparam int W   = 14;
  localparam int LSB = 7;
  localparam int IW  = 3;

  typedef logic [W-1:0] pktq_t[$];

  logic         clk = 1'b0;
  logic         reset, flush, in_valid;
  logic [W-1:0] in_packet;
  logic [1:0]   replay_iter;
  logic [P-1:0] pe_idle, bank_busy;

  logic         rdy_s, rdy_l, emp_s, emp_l, ful_s, ful_l;
  logic [P-1:0] dv_s, dv_l;
  logic [P*W-1:0] dp_s, dp_l;
  logic [3:0]   cnt_s, cnt_l;

  int checks = 0;
  int errors = 0;
  pktq_t qs, ql;

  always #5 clk = ~clk;

  rs_multi_issue #(.ENTRIES(E), .NUM_PE(P), .PKT_W(W), .ITER_LSB(LSB), .ITER_W(IW),
                   .BANK_STRICT(1)) u_strict (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_packet(in_packet),
    .in_ready(rdy_s), .replay_iter(replay_iter), .pe_idle(pe_idle), .bank_busy(bank_busy),
    .dp_valid(dv_s), .dp_packet(dp_s), .count(cnt_s), .rs_empty(emp_s), .rs_full(ful_s));

  rs_multi_issue #(.ENTRIES(E), .NUM_PE(P), .PKT_W(W), .ITER_LSB(LSB), .ITER_W(IW),
                   .BANK_STRICT(0)) u_loose (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_packet(in_packet),
    .in_ready(rdy_l), .replay_iter(replay_iter), .pe_idle(pe_idle), .bank_busy(bank_busy),
    .dp_valid(dv_l), .dp_packet(dp_l), .count(cnt_l), .rs_empty(emp_l), .rs_full(ful_l));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] mask, input logic [6:0] id);
    return {id[3:0], mask, id};
  endfunction

  // Reference: list candidates and eligible PEs, then pair them off in order.
  task automatic model(input pktq_t q, input bit strict, output logic [P-1:0] v,
                       output logic [P*W-1:0] pk, output bit [E-1:0] m);
    int  cand[$];
    int  pes[$];
    bit  anym = 0;
    int  ri   = int'(replay_iter);
    v = '0; pk = '0; m = '0;
    if (reset || flush) return;
    if (ri < IW) foreach (q[i]) if (q[i][LSB + ri]) anym = 1;
    foreach (q[i]) if (!anym || q[i][LSB + ri]) cand.push_back(i);
    for (int j = 0; j < P; j++)
      if (pe_idle[j] && (strict ? (bank_busy == '0) : !bank_busy[j])) pes.push_back(j);
    for (int n = 0; n < cand.size() && n < pes.size(); n++) begin
      v[pes[n]] = 1'b1;
      pk[pes[n]*W +: W] = q[cand[n]];
      m[cand[n]] = 1'b1;
    end
  endtask

  function automatic pktq_t next_q(input pktq_t q, input bit [E-1:0] m);
    pktq_t r;
    if (reset || flush) return r;
    foreach (q[i]) if (!m[i]) r.push_back(q[i]);
    if (in_valid && q.size() < E) r.push_back(in_packet);
    return r;
  endfunction

  task automatic step(input string tag, input int xvs = -1, input int xvl = -1);
    logic [P-1:0]   vs, vl;
    logic [P*W-1:0] ps, pl;
    bit   [E-1:0]   ms, ml;
    bit             rs_exp, rl_exp;
    logic [31:0]    xs, xl;
    @(negedge clk);
    model(qs, 1'b1, vs, ps, ms);
    model(ql, 1'b0, vl, pl, ml);
    rs_exp = reset ? 1'b1 : (!flush && qs.size() < E);
    rl_exp = reset ? 1'b1 : (!flush && ql.size() < E);
    chk({tag, ".s.dp_valid"},  dv_s,  vs);
    chk({tag, ".s.dp_packet"}, dp_s,  ps);
    chk({tag, ".s.count"},     cnt_s, qs.size());
    chk({tag, ".s.in_ready"},  rdy_s, rs_exp);
    chk({tag, ".s.empty"},     emp_s, qs.size() == 0);
    chk({tag, ".s.full"},      ful_s, qs.size() == E);
    chk({tag, ".l.dp_valid"},  dv_l,  vl);
    chk({tag, ".l.dp_packet"}, dp_l,  pl);
    chk({tag, ".l.count"},     cnt_l, ql.size());
    chk({tag, ".l.in_ready"},  rdy_l, rl_exp);
    chk({tag, ".l.empty"},     emp_l, ql.size() == 0);
    chk({tag, ".l.full"},      ful_l, ql.size() == E);
    xs = xvs; xl = xvl;
    if (xvs >= 0) chk({tag, ".s.plan_valid"}, dv_s, xs[P-1:0]);
    if (xvl >= 0) chk({tag, ".l.plan_valid"}, dv_l, xl[P-1:0]);
    qs = next_q(qs, ms);
    ql = next_q(ql, ml);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] p, input logic [P-1:0] idle,
                       input logic [P-1:0] busy, input logic [1:0] ri,
                       input bit fl = 1'b0, input bit rs = 1'b0);
    in_valid = v; in_packet = p; pe_idle = idle; bank_busy = busy;
    replay_iter = ri; flush = fl; reset = rs;
  endtask

  initial begin
    drive(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 0);

    // Push A,B,C then issue to PE0/PE2; C remains oldest.
    drive(1'b1, mk(3'b000, 7'd1), 4'b0000, 4'b0000, 2'd0); step("pushA");
    drive(1'b1, mk(3'b000, 7'd2), 4'b0000, 4'b0000, 2'd0); step("pushB");
    drive(1'b1, mk(3'b000, 7'd3), 4'b0000, 4'b0000, 2'd0); step("pushC");
    drive(1'b0, '0, 4'b0101, 4'b0000, 2'd0); step("issueAB", 4'b0101, 4'b0101);
    drive(1'b0, '0, 4'b0001, 4'b0000, 2'd0); step("issueC", 4'b0001, 4'b0001);

    // Fill, then offer while full with one issue.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, mk(3'($urandom), 7'(16 + k)), 4'b0000, 4'b0000, 2'd0);
      step("fill");
    end
    drive(1'b1, mk(3'b000, 7'd40), 4'b0001, 4'b0000, 2'd0); step("fullissue", 4'b0001, 4'b0001);
    drive(1'b0, '0, 4'b0000, 4'b0000, 2'd0); step("after_full");

    drive(1'b1, mk(3'b000, 7'd41), 4'b1111, 4'b0000, 2'd0, 1'b1); step("flush", 0, 0);
    drive(1'b0, '0, 4'b0000, 4'b0000, 2'd0); step("post_flush");

    // Iteration preference.
    drive(1'b1, mk(3'b001, 7'd50), 4'b0000, 4'b0000, 2'd0); step("pushI0");
    drive(1'b1, mk(3'b100, 7'd51), 4'b0000, 4'b0000, 2'd0); step("pushI1");
    drive(1'b1, mk(3'b100, 7'd52), 4'b0000, 4'b0000, 2'd0); step("pushI2");
    drive(1'b0, '0, 4'b0001, 4'b0000, 2'd2); step("iterB", 4'b0001, 4'b0001);
    drive(1'b0, '0, 4'b0001, 4'b0000, 2'd2); step("iterC", 4'b0001, 4'b0001);
    drive(1'b0, '0, 4'b0001, 4'b0000, 2'd1); step("iterA", 4'b0001, 4'b0001);

    // Bank blocking modes.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(3'b000, 7'(60 + k)), 4'b0000, 4'b0000, 2'd0);
      step("pushBk");
    end
    drive(1'b0, '0, 4'b1111, 4'b1000, 2'd0); step("bank", 4'b0000, 4'b0111);

    // Reset mid-stream.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk(3'b010, 7'(70 + k)), 4'b0000, 4'b0000, 2'd0);
      step("pushR");
    end
    drive(1'b1, mk(3'b000, 7'd80), 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1); step("midreset", 0, 0);
    drive(1'b0, '0, 4'b1111, 4'b0000, 2'd0); step("post_reset", 0, 0);

    // Random traffic, including out-of-range replay_iter.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 3) != 0), W'($urandom),
            P'($urandom_range(0, 2) == 0 ? $urandom : 0),
            P'($urandom_range(0, 3) == 0 ? $urandom : 0),
            2'($urandom),
            ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) == 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
